// File: rtl/instr_fetch_mem.sv
// Program store and fetch stage: byte-serial program load over valid/ready,
// then registered instruction fetch from the datapath PC while running.
module instr_fetch_mem #(
    parameter int          ADDR_W = 8,
    parameter int          DEPTH  = 256,
    parameter logic [7:0]  FILL   = 8'h00
) (
    input  logic              _CLK,
    input  logic              _RESET,
    input  logic [ADDR_W-1:0] PC,
    output logic [7:0]        instruction,
    output logic              run,
    input  logic              load_start,
    input  logic              load_end,
    input  logic              wr_valid,
    input  logic [7:0]        wr_data,
    output logic              wr_ready,
    input  logic              run_start,
    input  logic              run_stop,
    output logic [ADDR_W:0]   prog_len,
    output logic              load_full
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam int               IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  LAST_L  = (ADDR_W + 1)'(DEPTH - 1);

    logic [7:0]        mem [0:DEPTH-1];

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [ADDR_W:0]   wr_ptr_reg;
    logic [ADDR_W:0]   prog_len_reg;
    logic              load_full_reg;
    logic              run_reg;
    logic              fetch_hit_reg;
    logic [7:0]        rd_data_reg;

    logic              xfer;
    logic              last_xfer;
    logic              fetch_en;
    logic              fetch_in_range;

    assign wr_ready       = (state_reg == ST_LOAD) && (prog_len_reg < DEPTH_L);
    assign xfer           = wr_valid && wr_ready;
    assign last_xfer      = xfer && (prog_len_reg == LAST_L);
    assign fetch_en       = (state_reg == ST_RUN) && !run_stop;
    // Unsigned ADDR_W+1 compare so PC=2^ADDR_W-1 is reachable with a full store
    assign fetch_in_range = ({1'b0, PC} < prog_len_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (load_start) begin
                    state_next = ST_LOAD;
                end else if (run_start && (prog_len_reg != '0)) begin
                    state_next = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (load_end || last_xfer) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (run_stop) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge _CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_reg     <= ST_IDLE;
            wr_ptr_reg    <= '0;
            prog_len_reg  <= '0;
            load_full_reg <= 1'b0;
            run_reg       <= 1'b0;
            fetch_hit_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            run_reg       <= (state_next == ST_RUN);
            fetch_hit_reg <= fetch_en && fetch_in_range;
            if ((state_reg == ST_IDLE) && load_start) begin
                wr_ptr_reg    <= '0;
                prog_len_reg  <= '0;
                load_full_reg <= 1'b0;
            end else if (xfer) begin
                wr_ptr_reg   <= wr_ptr_reg + 1'b1;
                prog_len_reg <= prog_len_reg + 1'b1;
                if (last_xfer) begin
                    load_full_reg <= 1'b1;
                end
            end
        end
    end

    // Storage is never reset; prog_len gates what is reachable
    always_ff @(posedge _CLK) begin
        if (xfer) begin
            mem[wr_ptr_reg[IDX_W-1:0]] <= wr_data;
        end
        if (fetch_en) begin
            rd_data_reg <= mem[PC[IDX_W-1:0]];
        end
    end

    assign instruction = fetch_hit_reg ? rd_data_reg : FILL;
    assign run         = run_reg;
    assign prog_len    = prog_len_reg;
    assign load_full   = load_full_reg;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: a full-size store and a DEPTH=4 store
// driven side by side, checked against hand-computed values.
module tb_instr_fetch_mem;

    logic       clk;
    logic       rst_n;

    logic [7:0] pc;
    logic [7:0] instruction;
    logic       run;
    logic       load_start, load_end, wr_valid, wr_ready, run_start, run_stop;
    logic [7:0] wr_data;
    logic [8:0] prog_len;
    logic       load_full;

    logic [7:0] s_pc;
    logic [7:0] s_instruction;
    logic       s_run;
    logic       s_load_start, s_load_end, s_wr_valid, s_wr_ready, s_run_start, s_run_stop;
    logic [7:0] s_wr_data;
    logic [8:0] s_prog_len;
    logic       s_load_full;

    int checks = 0;
    int errors = 0;

    instr_fetch_mem #(.ADDR_W(8), .DEPTH(256), .FILL(8'h00)) u_dut (
        ._CLK(clk), ._RESET(rst_n), .PC(pc), .instruction(instruction), .run(run),
        .load_start(load_start), .load_end(load_end), .wr_valid(wr_valid),
        .wr_data(wr_data), .wr_ready(wr_ready), .run_start(run_start),
        .run_stop(run_stop), .prog_len(prog_len), .load_full(load_full)
    );

    instr_fetch_mem #(.ADDR_W(8), .DEPTH(4), .FILL(8'h00)) u_small (
        ._CLK(clk), ._RESET(rst_n), .PC(s_pc), .instruction(s_instruction), .run(s_run),
        .load_start(s_load_start), .load_end(s_load_end), .wr_valid(s_wr_valid),
        .wr_data(s_wr_data), .wr_ready(s_wr_ready), .run_start(s_run_start),
        .run_stop(s_run_stop), .prog_len(s_prog_len), .load_full(s_load_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] prog [0:5];
    logic [7:0] pcs  [0:7];
    logic [7:0] exps [0:7];

    initial begin
        prog = '{8'h73, 8'h4D, 8'h74, 8'hB7, 8'h05, 8'hC2};
        pcs  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd255};
        exps = '{8'h73, 8'h4D, 8'h74, 8'hB7, 8'h05, 8'hC2, 8'h00, 8'h00};

        rst_n = 1'b0;
        pc = '0; load_start = 0; load_end = 0; wr_valid = 0; wr_data = '0;
        run_start = 0; run_stop = 0;
        s_pc = '0; s_load_start = 0; s_load_end = 0; s_wr_valid = 0; s_wr_data = '0;
        s_run_start = 0; s_run_stop = 0;
        #23 rst_n = 1'b1;

        // Reset state and idle behaviour
        check("rst_instruction", 32'(instruction), 32'h00);
        check("rst_run", 32'(run), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_prog_len", 32'(prog_len), 32'd0);
        check("rst_load_full", 32'(load_full), 32'd0);
        repeat (5) tick();
        check("idle_instruction", 32'(instruction), 32'h00);
        check("idle_wr_ready", 32'(wr_ready), 32'd0);
        run_start = 1; tick(); run_start = 0; tick();
        check("empty_run_start_run", 32'(run), 32'd0);
        check("empty_run_start_wr_ready", 32'(wr_ready), 32'd0);

        // Six-byte load, load_end coincident with the last byte
        load_start = 1; tick(); load_start = 0;
        check("load_wr_ready", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1; wr_data = prog[i]; load_end = (i == 5);
            tick();
            check($sformatf("load_prog_len_%0d", i), 32'(prog_len), 32'(i + 1));
        end
        wr_valid = 0; load_end = 0;
        check("load_done_wr_ready", 32'(wr_ready), 32'd0);
        check("load_done_load_full", 32'(load_full), 32'd0);
        tick();
        check("load_done_prog_len", 32'(prog_len), 32'd6);

        // Fetch sequence
        run_start = 1; tick(); run_start = 0;
        check("run_entry", 32'(run), 32'd1);
        check("run_entry_instruction", 32'(instruction), 32'h00);
        for (int j = 0; j < 8; j++) begin
            pc = pcs[j];
            tick();
            check($sformatf("fetch_pc_%0d", pcs[j]), 32'(instruction), 32'(exps[j]));
            check($sformatf("fetch_run_%0d", j), 32'(run), 32'd1);
        end

        // run_stop with PC pointing at a valid word
        pc = 8'd0; tick();
        check("pre_stop_instruction", 32'(instruction), 32'h73);
        run_stop = 1; tick(); run_stop = 0;
        check("stop_run", 32'(run), 32'd0);
        check("stop_instruction", 32'(instruction), 32'h00);

        // DEPTH=4 store with wr_valid stuck high
        s_load_start = 1; tick(); s_load_start = 0;
        s_wr_valid = 1;
        for (int i = 0; i < 6; i++) begin
            s_wr_data = 8'h10 + 8'(i);
            tick();
            if (i == 3) begin
                check("small_full_prog_len", 32'(s_prog_len), 32'd4);
                check("small_full_flag", 32'(s_load_full), 32'd1);
                check("small_full_wr_ready", 32'(s_wr_ready), 32'd0);
            end
        end
        s_wr_valid = 0;
        check("small_after_prog_len", 32'(s_prog_len), 32'd4);
        s_run_start = 1; tick(); s_run_start = 0;
        check("small_run", 32'(s_run), 32'd1);
        for (int j = 0; j < 5; j++) begin
            s_pc = 8'(j);
            tick();
            check($sformatf("small_fetch_pc_%0d", j), 32'(s_instruction),
                  (j < 4) ? 32'(8'h10 + 8'(j)) : 32'h00);
        end

        // load_start and run_start together from IDLE: load wins
        load_start = 1; run_start = 1; tick(); load_start = 0; run_start = 0;
        check("both_run", 32'(run), 32'd0);
        check("both_wr_ready", 32'(wr_ready), 32'd1);
        check("both_prog_len", 32'(prog_len), 32'd0);

        // Three bytes then an asynchronous reset between edges
        wr_valid = 1;
        wr_data = 8'hAA; tick();
        wr_data = 8'hBB; tick();
        wr_data = 8'hCC; tick();
        wr_valid = 0;
        check("midload_prog_len", 32'(prog_len), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_prog_len", 32'(prog_len), 32'd0);
        check("async_rst_wr_ready", 32'(wr_ready), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        run_start = 1; tick(); run_start = 0; tick();
        check("post_rst_run", 32'(run), 32'd0);
        check("post_rst_instruction", 32'(instruction), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
